// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the 640x480@60 VGA raster.
//   - DEF_* default timing constants (pixels / lines) and derived totals
//   - CNT_W: width of the hc/vc raster counters
//   - DEF_CLK_DIV: default system clocks per pixel for the divided-clock build
//   - COLOR_*: 12-bit RGB constants used by the downstream pixel driver
//   - in_window(): half-open range test [lo, hi) at counter width
package vga_pkg;

  localparam int unsigned DEF_HPIXELS = 640;
  localparam int unsigned DEF_HFP     = 16;
  localparam int unsigned DEF_HSW     = 96;
  localparam int unsigned DEF_HBP     = 48;
  localparam int unsigned DEF_VPIXELS = 480;
  localparam int unsigned DEF_VFP     = 10;
  localparam int unsigned DEF_VSW     = 2;
  localparam int unsigned DEF_VBP     = 33;
  localparam int unsigned DEF_CLK_DIV = 4;

  localparam int unsigned DEF_HTOTAL = DEF_HPIXELS + DEF_HFP + DEF_HSW + DEF_HBP;
  localparam int unsigned DEF_VTOTAL = DEF_VPIXELS + DEF_VFP + DEF_VSW + DEF_VBP;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned FC_W  = 16;

  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hfff;
  localparam logic [11:0] COLOR_RED   = 12'hf00;
  localparam logic [11:0] COLOR_GREEN = 12'h0f0;
  localparam logic [11:0] COLOR_BLUE  = 12'h00f;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// vga_tick_gen: divides clk down to a one-clk-wide pixel enable.
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   px_tick  out registered enable, high one clk in every CLK_DIV;
//                first high CLK_DIV clocks after rst deasserts
module vga_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic px_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      px_tick <= 1'b0;
    end else if (div == DIV_LAST) begin
      div     <= '0;
      px_tick <= 1'b1;
    end else begin
      div     <= div + DW'(1);
      px_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster timing generator.
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   px_tick      out  pixel-rate enable (one clk wide)
//   hc / vc      out  raster counters, 0..HTOTAL-1 / 0..VTOTAL-1
//   hsync/vsync  out  active-low sync pulses
//   blank        out  high outside the visible area
//   frame_start  out  one-clk pulse after the raster wraps to (0,0)
//   frame_count  out  frames completed since reset, wraps at 16 bits
// Build option: define VGA_CLKDIV_EN to derive px_tick from a CLK_DIV
// divider (vga_tick_gen); otherwise clk is the pixel clock and px_tick
// stays high from the first cycle after reset.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HPIXELS = DEF_HPIXELS,
  parameter int unsigned HFP     = DEF_HFP,
  parameter int unsigned HSW     = DEF_HSW,
  parameter int unsigned HBP     = DEF_HBP,
  parameter int unsigned VPIXELS = DEF_VPIXELS,
  parameter int unsigned VFP     = DEF_VFP,
  parameter int unsigned VSW     = DEF_VSW,
  parameter int unsigned VBP     = DEF_VBP,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  output logic             px_tick,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int unsigned HTOTAL = HPIXELS + HFP + HSW + HBP;
  localparam int unsigned VTOTAL = VPIXELS + VFP + VSW + VBP;

  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(HPIXELS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(HPIXELS + HFP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HPIXELS + HFP + HSW);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(VPIXELS);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(VPIXELS + VFP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VPIXELS + VFP + VSW);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOTAL - 1);

  if (HTOTAL > (1 << CNT_W) || VTOTAL > (1 << CNT_W) || CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing: raster totals must fit the counters and CLK_DIV must be >= 1");
  end

`ifdef VGA_CLKDIV_EN
  vga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .px_tick (px_tick)
  );
`else
  always_ff @(posedge clk) begin
    if (rst) px_tick <= 1'b0;
    else     px_tick <= 1'b1;
  end
`endif

  logic [CNT_W-1:0] hc_nxt;
  logic [CNT_W-1:0] vc_nxt;
  logic             frame_wrap;

  always_comb begin
    hc_nxt     = hc;
    vc_nxt     = vc;
    frame_wrap = 1'b0;
    if (px_tick) begin
      if (hc == H_LAST) begin
        hc_nxt = '0;
        if (vc == V_LAST) begin
          vc_nxt     = '0;
          frame_wrap = 1'b1;
        end else begin
          vc_nxt = vc + CNT_W'(1);
        end
      end else begin
        hc_nxt = hc + CNT_W'(1);
      end
    end
  end

  // Sync/blank are decoded from the next counter values so the registered
  // flags line up with the registered hc/vc they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hsync       <= !in_window(hc_nxt, HS_START, HS_END);
      vsync       <= !in_window(vc_nxt, VS_START, VS_END);
      blank       <= (hc_nxt >= H_VIS) || (vc_nxt >= V_VIS);
      frame_start <= frame_wrap;
      if (frame_wrap) frame_count <= frame_count + FC_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: self-checking bench for vga_timing.
// dut_a uses the default 640x480 timing (line-level checks); dut_b uses a
// shrunken raster so whole frames fit in a short run. A tick-count model
// predicts every output each cycle from plain arithmetic on the number of
// pixel ticks since reset. Honours VGA_CLKDIV_EN (CLK_DIV = 4) when defined.
module tb_vga_timing;

`ifdef VGA_CLKDIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  // small raster for dut_b: 32 x 13 = 416 ticks per frame
  localparam int B_HP = 16, B_HFP = 4, B_HSW = 6, B_HBP = 6;
  localparam int B_VP = 6,  B_VFP = 2, B_VSW = 2, B_VBP = 3;
  localparam int B_HT = B_HP + B_HFP + B_HSW + B_HBP;
  localparam int FA = 800 * 525;
  localparam int FB = B_HT * (B_VP + B_VFP + B_VSW + B_VBP);

  typedef struct packed {
    logic        px;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int         t;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs;
    logic       bl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        px_a, hs_a, vs_a, bl_a, fs_a, px_b, hs_b, vs_b, bl_b, fs_b;
  logic [9:0]  hc_a, vc_a, hc_b, vc_b;
  logic [15:0] fc_a, fc_b;

  vga_timing #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .px_tick(px_a), .hc(hc_a), .vc(vc_a), .hsync(hs_a),
    .vsync(vs_a), .blank(bl_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing #(.HPIXELS(B_HP), .HFP(B_HFP), .HSW(B_HSW), .HBP(B_HBP),
               .VPIXELS(B_VP), .VFP(B_VFP), .VSW(B_VSW), .VBP(B_VBP), .CLK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .px_tick(px_b), .hc(hc_b), .vc(vc_b), .hsync(hs_b),
    .vsync(vs_b), .blank(bl_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {px_a, hc_a, vc_a, hs_a, vs_a, bl_a, fs_a, fc_a};
  assign obs_b = {px_b, hc_b, vc_b, hs_b, vs_b, bl_b, fs_b, fc_b};

  // reference: m_k = clocks since reset release, m_t = pixel ticks since reset
  int   m_k = 0, m_t = 0;
  logic m_px = 1'b0, m_fs_a = 1'b0, m_fs_b = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_k <= 0; m_t <= 0; m_px <= 1'b0; m_fs_a <= 1'b0; m_fs_b <= 1'b0;
    end else begin
      m_k  <= m_k + 1;
      m_px <= ((m_k + 1) % DIV) == 0;
      if (m_px) begin
        m_t    <= m_t + 1;
        m_fs_a <= ((m_t + 1) % FA) == 0;
        m_fs_b <= ((m_t + 1) % FB) == 0;
      end else begin
        m_fs_a <= 1'b0;
        m_fs_b <= 1'b0;
      end
    end
  end

  function automatic obs_t model(int t, logic px, logic fs, int hp, int hfp, int hsw, int hbp,
                                 int vp, int vfp, int vsw, int vbp);
    obs_t o;
    int ht = hp + hfp + hsw + hbp;
    int vt = vp + vfp + vsw + vbp;
    int h  = t % ht;
    int v  = (t / ht) % vt;
    o.px = px;
    o.hc = 10'(h);
    o.vc = 10'(v);
    o.hs = !(h >= hp + hfp && h < hp + hfp + hsw);
    o.vs = !(v >= vp + vfp && v < vp + vfp + vsw);
    o.bl = (h >= hp) || (v >= vp);
    o.fs = fs;
    o.fc = 16'((t / (ht * vt)) % 65536);
    return o;
  endfunction

  int checks = 0, errors = 0, cyc = 0;

  task automatic cmp_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got px=%b hc=%0d vc=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d exp px=%b hc=%0d vc=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d",
               name, cyc, got.px, got.hc, got.vc, got.hs, got.vs, got.bl, got.fs, got.fc,
               exp.px, exp.hc, exp.vc, exp.hs, exp.vs, exp.bl, exp.fs, exp.fc);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d exp %0d", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    cmp_obs("model_a", obs_a, model(m_t, m_px, m_fs_a, 640, 16, 96, 48, 480, 10, 2, 33));
    cmp_obs("model_b", obs_b, model(m_t, m_px, m_fs_b, B_HP, B_HFP, B_HSW, B_HBP,
                                    B_VP, B_VFP, B_VSW, B_VBP));
  endtask

  task automatic wait_t(input int target, input int budget);
    int n = 0;
    while (m_t < target && n < budget) begin
      step();
      n++;
    end
    chk("wait_tick_count", m_t, target);
  endtask

  localparam obs_t RST_OBS = '{px: 1'b0, hc: 10'd0, vc: 10'd0, hs: 1'b1, vs: 1'b1,
                               bl: 1'b0, fs: 1'b0, fc: 16'd0};

  vec_t tbl[10];

  initial begin
    int first_px, n, hs_low, bl_cnt, fs_cnt, vs_low;

    tbl[0] = '{639,  10'd639, 10'd0, 1'b1, 1'b0};
    tbl[1] = '{640,  10'd640, 10'd0, 1'b1, 1'b1};
    tbl[2] = '{655,  10'd655, 10'd0, 1'b1, 1'b1};
    tbl[3] = '{656,  10'd656, 10'd0, 1'b0, 1'b1};
    tbl[4] = '{751,  10'd751, 10'd0, 1'b0, 1'b1};
    tbl[5] = '{752,  10'd752, 10'd0, 1'b1, 1'b1};
    tbl[6] = '{799,  10'd799, 10'd0, 1'b1, 1'b1};
    tbl[7] = '{800,  10'd0,   10'd1, 1'b1, 1'b0};
    tbl[8] = '{1599, 10'd799, 10'd1, 1'b1, 1'b1};
    tbl[9] = '{1600, 10'd0,   10'd2, 1'b1, 1'b0};

    rst = 1'b1;
    repeat (3) step();
    cmp_obs("reset_state_a", obs_a, RST_OBS);
    cmp_obs("reset_state_b", obs_b, RST_OBS);

    // first pixel tick after release, then first counter advance
    rst = 1'b0;
    first_px = 0;
    n = 0;
    while (first_px == 0 && n < 4 * DIV + 4) begin
      step();
      n++;
      if (px_a) first_px = n;
    end
    chk("first_px_tick_delay", first_px, DIV);
    chk("hc_before_first_tick", int'(hc_a), 0);
    step();
    chk("hc_after_first_tick", int'(hc_a), 1);
    chk("px_tick_after_first", int'(px_a), (DIV == 1) ? 1 : 0);

    for (int i = 0; i < 10; i++) begin
      wait_t(tbl[i].t, 2000 * DIV);
      chk("vec_hc", int'(hc_a), int'(tbl[i].hc));
      chk("vec_vc", int'(vc_a), int'(tbl[i].vc));
      chk("vec_hsync", int'(hs_a), int'(tbl[i].hs));
      chk("vec_blank", int'(bl_a), int'(tbl[i].bl));
    end

    // one full line (vc=2): hsync low 96 ticks, blank 160 ticks
    hs_low = 0;
    bl_cnt = 0;
    n = 0;
    while (m_t < 2400 && n < 1000 * DIV) begin
      if (!hs_a) hs_low++;
      if (bl_a) bl_cnt++;
      step();
      n++;
    end
    chk("line_hsync_low_clks", hs_low, 96 * DIV);
    chk("line_blank_clks", bl_cnt, 160 * DIV);

    // mid-frame reset on dut_b at (20,4)
    n = 0;
    while ((m_t % FB) != 4 * B_HT + 20 && n < 2 * FB * DIV) begin
      step();
      n++;
    end
    chk("mid_reset_hc_b", int'(hc_b), 20);
    chk("mid_reset_vc_b", int'(vc_b), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp_obs("mid_reset_a", obs_a, RST_OBS);
    cmp_obs("mid_reset_b", obs_b, RST_OBS);

    // three frames on dut_b
    fs_cnt = 0;
    vs_low = 0;
    n = 0;
    while (m_t < 3 * FB && n < 4 * FB * DIV) begin
      step();
      n++;
      if (fs_b) fs_cnt++;
      if (!vs_b) vs_low++;
    end
    chk("frame_wrap_hc_b", int'(hc_b), 0);
    chk("frame_wrap_vc_b", int'(vc_b), 0);
    chk("frame_start_at_wrap", int'(fs_b), 1);
    repeat (DIV) begin
      step();
      if (fs_b) fs_cnt++;
      if (!vs_b) vs_low++;
    end
    chk("frame_start_pulses_clks", fs_cnt, 3);
    chk("vsync_low_clks_3_frames", vs_low, 3 * B_VSW * B_HT * DIV);
    chk("frame_count_after_3", int'(fc_b), 3);

    // randomized run lengths with random reset bursts
    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(600, 1);
      repeat (n) step();
      if ($urandom_range(1, 0) == 1) begin
        rst = 1'b1;
        n = $urandom_range(3, 1);
        repeat (n) step();
        rst = 1'b0;
      end
    end
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
